spi_xfer_engine: RTL

SPI master transfer engine that owns the SPI-side port of the dual-port byte buffer.
- On a host start command it reads bytes from the buffer, shifts them out on mosi and captures miso, MSB first, SPI mode 0.
- Each received byte is written back in place, at the same address it was read from.
- It sits between the host register block (start/length/divider/status) and the SPI pins.

---
 rtl/spimaster_pkg.sv | 62 ++++++
 rtl/spi_sclk_gen.sv | 53 +++++
 rtl/spi_xfer_engine.sv | 198 +++++++++++++++++++
 3 files changed

// File: rtl/spimaster_pkg.sv
// -----------------------------------------------------------------------------
// spimaster_pkg
// Shared types, constants and bit-order helpers for the SPI transfer engine.
//   state_t        : transfer FSM states
//   BITS_PER_BYTE  : bits shifted per buffer byte
//   CLK_DIV_BITS   : width of the SCLK half-period divider setting
//   shift_in       : inserts a received bit into the rx shift register
//   shift_out      : advances the tx shift register by one bit
//   line_bit       : picks the tx bit currently presented on mosi
// -----------------------------------------------------------------------------
package spimaster_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    FETCH = 3'd1,
    LOAD  = 3'd2,
    SHIFT = 3'd3,
    STORE = 3'd4,
    DONE  = 3'd5
  } state_t;

  localparam int BITS_PER_BYTE = 8;
  localparam int CLK_DIV_BITS  = 8;
  localparam int BIT_CNT_BITS  = 3;

  // Received bits enter at bit 0 for MSB-first order and at bit 7 for LSB-first.
  function automatic logic [7:0] shift_in(input logic [7:0] cur,
                                          input logic       bit_in,
                                          input logic       lsb_first);
    logic [7:0] res;
    if (lsb_first) begin
      res = {bit_in, cur[7:1]};
    end else begin
      res = {cur[6:0], bit_in};
    end
    return res;
  endfunction

  // Transmit register moves toward the bit that is presented on mosi next.
  function automatic logic [7:0] shift_out(input logic [7:0] cur,
                                           input logic       lsb_first);
    logic [7:0] res;
    if (lsb_first) begin
      res = {1'b0, cur[7:1]};
    end else begin
      res = {cur[6:0], 1'b0};
    end
    return res;
  endfunction

  function automatic logic line_bit(input logic [7:0] cur,
                                    input logic       lsb_first);
    logic res;
    if (lsb_first) begin
      res = cur[0];
    end else begin
      res = cur[7];
    end
    return res;
  endfunction

endpackage

// File: rtl/spi_sclk_gen.sv
// -----------------------------------------------------------------------------
// spi_sclk_gen
// SCLK divider for the SPI transfer engine. While enabled, a counter runs
// 0..i_div and SCLK toggles at terminal count, giving a half-period of
// i_div+1 clk cycles. When disabled the counter is held clear and SCLK low,
// so every byte starts from a fresh half-period.
// Ports:
//   i_clk, i_rst : system clock, synchronous active-high reset
//   i_en         : run the divider (engine is in its shift phase)
//   i_div        : half-period setting, latched by the engine
//   o_sclk       : registered SPI clock, idles low
//   o_rise       : strobe, SCLK goes high at the coming clk edge
//   o_fall       : strobe, SCLK goes low at the coming clk edge
// -----------------------------------------------------------------------------
module spi_sclk_gen
  import spimaster_pkg::*;
(
  input  logic                    i_clk,
  input  logic                    i_rst,
  input  logic                    i_en,
  input  logic [CLK_DIV_BITS-1:0] i_div,
  output logic                    o_sclk,
  output logic                    o_rise,
  output logic                    o_fall
);

  logic [CLK_DIV_BITS-1:0] r_div_cnt;
  logic                    r_sclk;
  logic                    w_tc;

  // Strobes announce the toggle that the register below performs this edge.
  assign w_tc   = i_en && (r_div_cnt == i_div);
  assign o_rise = w_tc && !r_sclk;
  assign o_fall = w_tc && r_sclk;
  assign o_sclk = r_sclk;

  // Divider counter and SCLK toggle register.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_div_cnt <= '0;
      r_sclk    <= 1'b0;
    end else if (!i_en) begin
      r_div_cnt <= '0;
      r_sclk    <= 1'b0;
    end else if (w_tc) begin
      r_div_cnt <= '0;
      r_sclk    <= ~r_sclk;
    end else begin
      r_div_cnt <= r_div_cnt + CLK_DIV_BITS'(1);
    end
  end

endmodule

// File: rtl/spi_xfer_engine.sv
// -----------------------------------------------------------------------------
// spi_xfer_engine
// SPI master (mode 0) owning the SPI-side port of the dual-port byte buffer.
// On start it reads bytes 0..xfer_len-1, shifts each out on mosi while
// capturing miso, and writes the received byte back to the same address.
// Per byte: FETCH, LOAD, 16 SCLK half-periods of SHIFT, STORE, i.e.
// 3 + 16*(clk_div+1) cycles; cs_n stays low across all bytes.
// Optional build macro: SPIMASTER_LSB_FIRST_EN adds the lsb_first input
// (sampled on start) selecting LSB-first order; without it order is MSB first.
// Ports:
//   clk, rst         : system clock, synchronous active-high reset
//   start            : one-cycle pulse, accepted only in IDLE
//   xfer_len         : byte count 0..num_bytes, sampled on start
//   clk_div          : SCLK half-period minus one, sampled on start
//   busy, done       : transfer in progress / one-cycle completion pulse
//   b_addr, b_wr_val, b_wr_en, b_rd_val : buffer SPI port (1-cycle read)
//   cs_n, sclk, mosi, miso              : SPI pins
//   lsb_first        : bit-order select (only with SPIMASTER_LSB_FIRST_EN)
// -----------------------------------------------------------------------------
module spi_xfer_engine
  import spimaster_pkg::*;
#(
  parameter  int num_bytes = 8192,
  localparam int addr_bits = $clog2(num_bytes)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic [addr_bits:0]      xfer_len,
  input  logic [CLK_DIV_BITS-1:0] clk_div,
  output logic                    busy,
  output logic                    done,
  output logic [addr_bits-1:0]    b_addr,
  output logic [7:0]              b_wr_val,
  input  logic [7:0]              b_rd_val,
  output logic                    b_wr_en,
  output logic                    cs_n,
  output logic                    sclk,
  output logic                    mosi,
  input  logic                    miso
`ifdef SPIMASTER_LSB_FIRST_EN
  ,
  input  logic                    lsb_first
`endif
);

  state_t                  r_state;
  logic [addr_bits:0]      r_len;
  logic [CLK_DIV_BITS-1:0] r_div;
  logic [7:0]              r_tx_shift;
  logic [7:0]              r_rx_shift;
  logic [BIT_CNT_BITS-1:0] r_bit_cnt;

  logic                    w_shift_en;
  logic                    w_rise;
  logic                    w_fall;
  logic                    w_accept;
  logic                    w_lsb;
  logic [7:0]              w_tx_next;
  logic                    w_last_byte;

  // A non-empty start in IDLE is the only way into a transfer.
  assign w_accept    = (r_state == IDLE) && start && (xfer_len != '0);
  assign w_shift_en  = (r_state == SHIFT);
  assign w_tx_next   = shift_out(r_tx_shift, w_lsb);
  // b_addr is the byte index, so index+1 == length marks the final byte.
  assign w_last_byte = (({1'b0, b_addr} + (addr_bits+1)'(1)) == r_len);

`ifdef SPIMASTER_LSB_FIRST_EN
  logic r_lsb_first;

  // Bit order is frozen for the whole transfer at the accepted start.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_lsb_first <= 1'b0;
    end else if (w_accept) begin
      r_lsb_first <= lsb_first;
    end else begin
      r_lsb_first <= r_lsb_first;
    end
  end

  assign w_lsb = r_lsb_first;
`else
  assign w_lsb = 1'b0;
`endif

  spi_sclk_gen u_sclk_gen (
    .i_clk  (clk),
    .i_rst  (rst),
    .i_en   (w_shift_en),
    .i_div  (r_div),
    .o_sclk (sclk),
    .o_rise (w_rise),
    .o_fall (w_fall)
  );

  // Transfer FSM with registered pin, buffer and status outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= IDLE;
      r_len      <= '0;
      r_div      <= '0;
      r_tx_shift <= '0;
      r_rx_shift <= '0;
      r_bit_cnt  <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      cs_n       <= 1'b1;
      mosi       <= 1'b0;
      b_addr     <= '0;
      b_wr_val   <= 8'h00;
      b_wr_en    <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          done    <= 1'b0;
          b_wr_en <= 1'b0;
          if (start && (xfer_len == '0)) begin
            // Empty transfer: report completion without touching the bus.
            done    <= 1'b1;
            r_state <= DONE;
          end else if (w_accept) begin
            r_len   <= xfer_len;
            r_div   <= clk_div;
            b_addr  <= '0;
            cs_n    <= 1'b0;
            busy    <= 1'b1;
            r_state <= FETCH;
          end else begin
            r_state <= IDLE;
          end
        end

        FETCH: begin
          // Buffer samples b_addr at this edge; data is valid in LOAD.
          r_state <= LOAD;
        end

        LOAD: begin
          r_tx_shift <= b_rd_val;
          mosi       <= line_bit(b_rd_val, w_lsb);
          r_bit_cnt  <= '0;
          r_state    <= SHIFT;
        end

        SHIFT: begin
          if (w_rise) begin
            r_rx_shift <= shift_in(r_rx_shift, miso, w_lsb);
          end else if (w_fall) begin
            r_tx_shift <= w_tx_next;
            mosi       <= line_bit(w_tx_next, w_lsb);
            r_bit_cnt  <= r_bit_cnt + BIT_CNT_BITS'(1);
            if (r_bit_cnt == BIT_CNT_BITS'(BITS_PER_BYTE - 1)) begin
              // Eighth falling edge: rx is complete since the last rise.
              b_wr_en  <= 1'b1;
              b_wr_val <= r_rx_shift;
              r_state  <= STORE;
            end else begin
              r_state <= SHIFT;
            end
          end else begin
            r_state <= SHIFT;
          end
        end

        STORE: begin
          b_wr_en <= 1'b0;
          if (w_last_byte) begin
            done    <= 1'b1;
            cs_n    <= 1'b1;
            busy    <= 1'b0;
            mosi    <= 1'b0;
            r_state <= DONE;
          end else begin
            b_addr  <= b_addr + addr_bits'(1);
            r_state <= FETCH;
          end
        end

        DONE: begin
          done    <= 1'b0;
          r_state <= IDLE;
        end

        default: begin
          busy    <= 1'b0;
          done    <= 1'b0;
          cs_n    <= 1'b1;
          mosi    <= 1'b0;
          b_wr_en <= 1'b0;
          r_state <= IDLE;
        end
      endcase
    end
  end

endmodule
